// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single IF/ID pipeline register with
// stall/flush handling, and a FETCH/HALT/FAULT control state machine.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] count_q, count_d;

    logic        advance;
    logic        redirect_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ifpc_q  <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        count_d = count_q;

        advance        = !valid_q || id_ready;
        redirect_legal = (redirect_target[1:0] == 2'b00) && (redirect_target <= LAST_PC);

        case (state_q)
            FETCH, HALT: begin
                // Redirect wins over both advance and stall; it always flushes IF/ID.
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (redirect_legal) begin
                        pc_d    = redirect_target;
                        state_d = FETCH;
                    end else begin
                        state_d = FAULT;
                    end
                end else if (state_q == FETCH) begin
                    if (advance) begin
                        instr_d = imem_instr;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_d = count_q + 32'd1;
                        end
                        if (pc_q == LAST_PC) begin
                            state_d = HALT;
                        end
                    end
                end else if (id_ready) begin
                    valid_d = 1'b0;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);
    assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 Parameter IMEM_BYTES, default 1024: instruction memory size in bytes; legal PC range is 0 to IMEM_BYTES-4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_addr  output  32  byte address to instruction memory; equals pc register, combinational.
REQ-006 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump taken; pulse one cycle.
REQ-008 redirect_target  input  32  absolute byte target; sampled when redirect_valid=1.
REQ-009 id_ready  input  1  decode stage accepts if_id_* this cycle.
REQ-010 if_id_valid  output  1  if_id_instr and if_id_pc hold a valid fetched instruction.
REQ-011 if_id_instr  output  32  registered instruction word.
REQ-012 if_id_pc  output  32  byte address of if_id_instr.
REQ-013 halted  output  1  PC ran past IMEM_BYTES-4; no further fetch.
REQ-014 fault  output  1  misaligned or out-of-range redirect received; sticky until reset.
REQ-015 fetch_count  output  32  number of instructions loaded into the IF/ID register; saturates at 32'hFFFF_FFFF.

Function
REQ-016 State machine states FETCH, HALT and FAULT; reset state is FETCH.
REQ-017 Define "advance" = (if_id_valid==0) or (id_ready==1).
REQ-018 In FETCH with advance and no redirect: on the clock edge, if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4, fetch_count+=1; latency is 1 cycle from imem_addr to if_id_valid.
REQ-019 In FETCH without advance: pc and all if_id_* outputs hold unchanged (stall); no new fetch.
REQ-020 While if_id_valid=1 and id_ready=0, if_id_instr and if_id_pc shall remain stable.
REQ-021 The redirect has priority over advance and stall: with redirect_valid=1 and a legal target (bits[1:0]==0 and target<=IMEM_BYTES-4), pc<=redirect_target, if_id_valid<=0 (flush), no fetch that cycle, state<=FETCH.
REQ-022 With redirect_valid=1 and an illegal target, state<=FAULT, fault<=1, if_id_valid<=0, and pc holds.
REQ-023 In FETCH, when a fetch is performed at pc==IMEM_BYTES-4, pc<=pc+4 and state<=HALT; halted=1 from the next cycle.
REQ-024 In HALT: no fetch and fetch_count frozen; a pending if_id_valid drains normally (it clears when id_ready=1); a legal redirect returns the block to FETCH and clears halted.
REQ-025 In FAULT: if_id_valid=0, no fetch, and redirects are ignored; only rst_n exits this state.
REQ-026 A redirect coincident with id_ready=1 counts the current output as consumed; the flush still applies.
REQ-027 pc arithmetic is 32-bit modulo; pc increments only by 4 or loads on a redirect.
REQ-028 imem_addr bits[1:0] shall always be 0.

Reset
REQ-029 On rst_n=0, immediately and regardless of clk: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc=0, halted=0, fault=0, fetch_count=0.
REQ-030 Reset asserted mid-stall, mid-redirect or in HALT/FAULT overrides everything; the first fetch occurs on the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset release with id_ready=1 held and memory words k at address 4k -> imem_addr 0,4,8,... each cycle; if_id_instr=0,1,2 on cycles 1,2,3; fetch_count=3 after 3 edges.
REQ-032 id_ready=0 for 3 cycles with if_id_pc=8 -> if_id_pc stays 8, if_id_instr stays constant, imem_addr stays 12, fetch_count unchanged; releasing id_ready resumes with if_id_pc=12.
REQ-033 redirect_valid pulse with target 0x40 while if_id_pc=0x10 -> next cycle if_id_valid=0 and imem_addr=0x40; the following cycle if_id_pc=0x40.
REQ-034 Free run to the end of memory (IMEM_BYTES=1024) -> last if_id_pc=0x3FC, halted=1, fetch_count=256 and frozen; a redirect to 0 clears halted and refetches from 0.
REQ-035 redirect_target=0x42 or 0x400 -> fault=1, if_id_valid=0; a later legal redirect does not clear the fault; pulsing rst_n clears fault and restarts at RESET_PC.
REQ-036 Asserting rst_n low between clock edges while stalled with if_id_valid=1 -> outputs reach their reset values with no clock edge.
